red_ex_pipe: RTL and testbench

//   Two-stage pipelined execute slice for the arithmetic/reduction opcodes (ADD, SUB, XOR, RED).

---
 rtl/red_ex_pipe.sv | 147 ++++++++++++++
 tb/tb_red_ex_pipe.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/red_ex_pipe.sv
// Two-stage execute slice for ADD/SUB/XOR/RED with saturating arithmetic and
// an architectural Z/V/N flag register that commits as results leave the pipe.
module red_ex_pipe #(
  parameter int DW    = 16,
  parameter int DST_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [DW-1:0]    in_a,
  input  logic [DW-1:0]    in_b,
  input  logic [DST_W-1:0] in_dst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_result,
  output logic [DST_W-1:0] out_dst,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_XOR = 2'b10,
    OP_RED = 2'b11
  } op_e;

  logic             s1_valid, s2_valid;
  op_e              s1_op, s2_op;
  logic [DST_W-1:0] s1_dst, s2_dst;
  logic [DW-1:0]    s1_res, s2_res;
  logic             s1_sat, s2_sat;
  logic [8:0]       s1_lo, s1_hi;

  logic s2_adv, s1_adv, accept, s2_load;

  assign s2_adv   = s2_valid & out_ready;
  assign s1_adv   = s1_valid & (~s2_valid | s2_adv);
  assign in_ready = ~flush & (~s1_valid | s1_adv);
  assign accept   = in_valid & in_ready;
  assign s2_load  = s1_adv & ~flush;

  // Stage-1 combinational compute
  op_e             op_d;
  logic [DW:0]     a_ext, b_ext, sum_ext;
  logic [DW-1:0]   res_d;
  logic            sat_d;
  logic [8:0]      lo_d, hi_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    op_d    = op_e'(in_op);
    a_ext   = {in_a[DW-1], in_a};
    b_ext   = {in_b[DW-1], in_b};
    sum_ext = (op_d == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
    res_d   = '0;
    sat_d   = 1'b0;
    lo_d    = {1'b0, in_a[7:0]}  + {1'b0, in_b[7:0]};
    hi_d    = {1'b0, in_a[15:8]} + {1'b0, in_b[15:8]};
    unique case (op_d)
      OP_ADD, OP_SUB: begin
        // Sign of the 17-bit result disagreeing with bit 15 means the 16-bit result wrapped.
        sat_d = sum_ext[DW] ^ sum_ext[DW-1];
        if (!sat_d)          res_d = sum_ext[DW-1:0];
        else if (sum_ext[DW]) res_d = {1'b1, {(DW-1){1'b0}}};
        else                 res_d = {1'b0, {(DW-1){1'b1}}};
      end
      OP_XOR:  res_d = in_a ^ in_b;
      default: res_d = '0;
    endcase
  end

  // Stage-2 combinational compute: final reduction add
  logic [9:0]    red_sum;
  logic [DW-1:0] s2_res_d;

  always_comb begin
    red_sum  = {1'b0, s1_lo} + {1'b0, s1_hi};
    s2_res_d = s1_res;
    if (s1_op == OP_RED) s2_res_d = {{(DW-10){1'b0}}, red_sum};
  end

  // Control state and architectural flags
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      flag_z   <= 1'b0;
      flag_v   <= 1'b0;
      flag_n   <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (accept)      s1_valid <= 1'b1;
      else if (s1_adv) s1_valid <= 1'b0;

      if (s1_adv)      s2_valid <= 1'b1;
      else if (s2_adv) s2_valid <= 1'b0;

      if (s2_adv) begin
        flag_z <= (s2_res == '0);
        if (s2_op == OP_ADD || s2_op == OP_SUB) begin
          flag_n <= s2_res[DW-1];
          flag_v <= s2_sat;
        end
      end
    end
  end

  // NOTE: stage-1 datapath is not reset; its contents are only consumed behind s1_valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op  <= op_d;
      s1_dst <= in_dst;
      s1_res <= res_d;
      s1_sat <= sat_d;
      s1_lo  <= lo_d;
      s1_hi  <= hi_d;
    end
  end

  // Output-facing stage-2 registers are reset so out_result/out_dst read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_op  <= OP_ADD;
      s2_dst <= '0;
      s2_res <= '0;
      s2_sat <= 1'b0;
    end else if (s2_load) begin
      s2_op  <= s1_op;
      s2_dst <= s1_dst;
      s2_res <= s2_res_d;
      s2_sat <= s1_sat;
    end
  end

  assign out_valid  = s2_valid;
  assign out_result = s2_res;
  assign out_dst    = s2_dst;

endmodule

// File: tb/tb_red_ex_pipe.sv
// Directed self-checking bench for red_ex_pipe: saturation, flags, reduction,
// backpressure, flush and asynchronous reset.
module tb_red_ex_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [15:0] in_a, in_b;
  logic [3:0]  in_dst;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_dst;
  logic        flag_z, flag_v, flag_n;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, XOR = 2'b10, RED = 2'b11;

  red_ex_pipe #(.DW(16), .DST_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_dst(in_dst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dst(out_dst),
    .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] dst);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_dst   = dst;
  endtask

  task automatic check_flags(input string tag, input logic z, input logic v, input logic n);
    check({tag, "_z"}, {31'd0, flag_z}, {31'd0, z});
    check({tag, "_v"}, {31'd0, flag_v}, {31'd0, v});
    check({tag, "_n"}, {31'd0, flag_n}, {31'd0, n});
  endtask

  task automatic check_out(input string tag, input logic [15:0] res, input logic [3:0] dst);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_result"}, {16'd0, out_result}, {16'd0, res});
    check({tag, "_dst"}, {28'd0, out_dst}, {28'd0, dst});
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = ADD;
    in_a = '0; in_b = '0; in_dst = '0; out_ready = 1'b1;
    #12 rst_n = 1'b1;
    cyc();

    // Reset state
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_result", {16'd0, out_result}, 32'd0);
    check("rst_out_dst", {28'd0, out_dst}, 32'd0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);

    // 1) ADD positive overflow saturates to 0x7FFF
    drive(ADD, 16'h7FFF, 16'h0001, 4'd3);
    cyc();
    in_valid = 1'b0;
    check("t1_lat1_valid", {31'd0, out_valid}, 32'd0);
    cyc();
    check_out("t1", 16'h7FFF, 4'd3);
    check_flags("t1_pre", 1'b0, 1'b0, 1'b0);
    cyc();
    check("t1_drained", {31'd0, out_valid}, 32'd0);
    check_flags("t1", 1'b0, 1'b1, 1'b0);

    // 2) SUB then XOR back-to-back, both zero
    drive(SUB, 16'h0005, 16'h0005, 4'd1);
    cyc();
    drive(XOR, 16'h00F0, 16'h00F0, 4'd2);
    cyc();
    in_valid = 1'b0;
    check_out("t2_sub", 16'h0000, 4'd1);
    cyc();
    check_out("t2_xor", 16'h0000, 4'd2);
    check_flags("t2_sub", 1'b1, 1'b0, 1'b0);
    cyc();
    check_flags("t2_xor", 1'b1, 1'b0, 1'b0);

    // 3) negative-overflow ADD sets V/N, then RED leaves V/N alone
    drive(ADD, 16'h8000, 16'hFFFF, 4'd9);
    cyc();
    drive(RED, 16'hFFFF, 16'hFFFF, 4'd10);
    cyc();
    drive(RED, 16'h0000, 16'h0000, 4'd11);
    check_out("t3_add", 16'h8000, 4'd9);
    cyc();
    in_valid = 1'b0;
    check_out("t3_red", 16'h03FC, 4'd10);
    check_flags("t3_add", 1'b0, 1'b1, 1'b1);
    cyc();
    check_out("t3_red0", 16'h0000, 4'd11);
    check_flags("t3_red", 1'b0, 1'b1, 1'b1);
    cyc();
    check_flags("t3_red0", 1'b1, 1'b1, 1'b1);

    // 4) Backpressure: 3 ops offered while out_ready=0
    out_ready = 1'b0;
    drive(ADD, 16'h0001, 16'h0002, 4'd4);
    cyc();
    drive(XOR, 16'hFF00, 16'h0F0F, 4'd5);
    cyc();
    drive(SUB, 16'h0003, 16'h0005, 4'd6);
    check("t4_in_ready_full", {31'd0, in_ready}, 32'd0);
    check_out("t4_stall0", 16'h0003, 4'd4);
    cyc();
    check("t4_in_ready_full2", {31'd0, in_ready}, 32'd0);
    check_out("t4_stall1", 16'h0003, 4'd4);
    cyc();
    check_out("t4_stall2", 16'h0003, 4'd4);
    out_ready = 1'b1;
    #1;
    check("t4_in_ready_release", {31'd0, in_ready}, 32'd1);
    cyc();
    in_valid = 1'b0;
    check_out("t4_b", 16'hF00F, 4'd5);
    check_flags("t4_a", 1'b0, 1'b0, 1'b0);
    cyc();
    check_out("t4_c", 16'hFFFE, 4'd6);
    cyc();
    check("t4_drained", {31'd0, out_valid}, 32'd0);
    check_flags("t4_c", 1'b0, 1'b0, 1'b1);

    // 5) Flush with two ops in flight; concurrent handshake is void
    drive(ADD, 16'h0001, 16'h0001, 4'd7);
    cyc();
    drive(ADD, 16'h0002, 16'h0002, 4'd8);
    cyc();
    in_valid = 1'b0;
    check_out("t5_inflight", 16'h0002, 4'd7);
    flush = 1'b1;
    #1;
    check("t5_in_ready_flush", {31'd0, in_ready}, 32'd0);
    cyc();
    flush = 1'b0;
    #1;
    check("t5_out_valid", {31'd0, out_valid}, 32'd0);
    check("t5_in_ready_after", {31'd0, in_ready}, 32'd1);
    check_flags("t5", 1'b0, 1'b0, 1'b1);
    cyc();
    check("t5_no_ghost", {31'd0, out_valid}, 32'd0);
    check_flags("t5_hold", 1'b0, 1'b0, 1'b1);

    // 6) Asynchronous reset mid-stall
    out_ready = 1'b0;
    drive(ADD, 16'h4000, 16'h4000, 4'd12);
    cyc();
    drive(XOR, 16'h1234, 16'h0000, 4'd13);
    cyc();
    in_valid = 1'b0;
    check_out("t6_stalled", 16'h7FFF, 4'd12);
    #2 rst_n = 1'b0;
    #1;
    check("t6_out_valid", {31'd0, out_valid}, 32'd0);
    check("t6_in_ready", {31'd0, in_ready}, 32'd1);
    check_flags("t6", 1'b0, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    cyc();
    check("t6_post_valid", {31'd0, out_valid}, 32'd0);

    // Normal operation after reset
    drive(ADD, 16'h1234, 16'h1111, 4'd14);
    cyc();
    in_valid = 1'b0;
    cyc();
    check_out("t7", 16'h2345, 4'd14);
    cyc();
    check_flags("t7", 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
